// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b, borrow-out, zero flag), one bit per clock, LSB first.
// A single full-subtractor cell is sequenced by an IDLE/RUN/DONE controller with start/abort/busy/done handshaking.

module serial_sub_cell (
    input  logic x_i,
    input  logic y_i,
    input  logic bin_i,
    output logic d_o,
    output logic bo_o
);
    assign d_o  = x_i ^ y_i ^ bin_i;
    assign bo_o = (~x_i & y_i) | (~(x_i ^ y_i) & bin_i);
endmodule

module serial_subtractor_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout,
    output logic             zero
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             brw_q, brw_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             bout_q, bout_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             step;
    logic             last_step;
    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] res_shift;

    // An abort on the final RUN edge suppresses both the DONE transition and the result update.
    assign accept    = (state_q == S_IDLE) && start;
    assign step      = (state_q == S_RUN) && !abort;
    assign last_step = step && (cnt_q == LAST_BIT);
    assign res_shift = {cell_d, res_q[WIDTH-1:1]};

    serial_sub_cell u_cell (
        .x_i   (sa_q[0]),
        .y_i   (sb_q[0]),
        .bin_i (brw_q),
        .d_o   (cell_d),
        .bo_o  (cell_bo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start) state_d = S_RUN;
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_RUN);
        done = (state_q == S_DONE);
    end

    always_comb begin
        sa_d   = sa_q;
        sb_d   = sb_q;
        res_d  = res_q;
        brw_d  = brw_q;
        cnt_d  = cnt_q;
        diff_d = diff_q;
        bout_d = bout_q;
        zero_d = zero_q;
        if (accept) begin
            sa_d  = a;
            sb_d  = b;
            res_d = '0;
            brw_d = 1'b0;
            cnt_d = '0;
        end else if (step) begin
            sa_d  = {1'b0, sa_q[WIDTH-1:1]};
            sb_d  = {1'b0, sb_q[WIDTH-1:1]};
            res_d = res_shift;
            brw_d = cell_bo;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_step) begin
                diff_d = res_shift;
                bout_d = cell_bo;
                zero_d = (res_shift == '0);
            end
        end
    end

    // Results reset to "0 - 0": diff=0, no borrow, zero asserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sa_q   <= '0;
            sb_q   <= '0;
            res_q  <= '0;
            brw_q  <= 1'b0;
            cnt_q  <= '0;
            diff_q <= '0;
            bout_q <= 1'b0;
            zero_q <= 1'b1;
        end else begin
            sa_q   <= sa_d;
            sb_q   <= sb_d;
            res_q  <= res_d;
            brw_q  <= brw_d;
            cnt_q  <= cnt_d;
            diff_q <= diff_d;
            bout_q <= bout_d;
            zero_q <= zero_d;
        end
    end

    assign diff = diff_q;
    assign bout = bout_q;
    assign zero = zero_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Self-checking bench for serial_subtractor_ctrl: an 8-bit instance for timing/control corners
// and a 4-bit instance swept over every operand pair.

module tb_serial_subtractor_ctrl;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       bout;
        logic       zero;
    } exp8_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] diff;
        logic       bout;
        logic       zero;
    } exp4_t;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       start8, abort8;
    logic [7:0] a8, b8;
    logic       busy8, done8;
    logic [7:0] diff8;
    logic       bout8, zero8;

    logic       start4, abort4;
    logic [3:0] a4, b4;
    logic       busy4, done4;
    logic [3:0] diff4;
    logic       bout4, zero4;

    int errors = 0;
    int checks = 0;

    exp8_t q8[$];
    exp4_t q4[$];
    exp8_t vecs[8];

    always #5 clk = ~clk;

    serial_subtractor_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start8),
        .abort (abort8),
        .a     (a8),
        .b     (b8),
        .busy  (busy8),
        .done  (done8),
        .diff  (diff8),
        .bout  (bout8),
        .zero  (zero8)
    );

    serial_subtractor_ctrl #(.WIDTH(4)) u_dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start4),
        .abort (abort4),
        .a     (a4),
        .b     (b4),
        .busy  (busy4),
        .done  (done4),
        .diff  (diff4),
        .bout  (bout4),
        .zero  (zero4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitors: every done pulse pops one expected result.
    always @(negedge clk) begin : mon8
        exp8_t e;
        if (rst_n) begin
            if (busy8 && done8) check("busy_done_overlap8", {busy8, done8}, 2'b10);
            if (done8) begin
                if (q8.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done8: got done=1 expected no done (diff=0x%0h)", diff8);
                end else begin
                    e = q8.pop_front();
                    check("diff8", diff8, e.diff);
                    check("bout8", bout8, e.bout);
                    check("zero8", zero8, e.zero);
                    $display("op8 a=%0d b=%0d -> diff=%0d bout=%0b zero=%0b", e.a, e.b, diff8, bout8, zero8);
                end
            end
        end
    end

    always @(negedge clk) begin : mon4
        exp4_t e;
        if (rst_n) begin
            if (busy4 && done4) check("busy_done_overlap4", {busy4, done4}, 2'b10);
            if (done4) begin
                if (q4.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done4: got done=1 expected no done (diff=0x%0h)", diff4);
                end else begin
                    e = q4.pop_front();
                    check("diff4", diff4, e.diff);
                    check("bout4", bout4, e.bout);
                    check("zero4", zero4, e.zero);
                    $display("op4 a=%0d b=%0d -> diff=%0d bout=%0b zero=%0b", e.a, e.b, diff4, bout4, zero4);
                end
            end
        end
    end

    // Counts negedges until done8 is seen (bounded), and how many of them had busy8 high.
    task automatic wait_done8(output int n, output int nb);
        n  = 0;
        nb = 0;
        while (!done8 && n < 40) begin
            if (busy8) nb++;
            n++;
            @(negedge clk);
        end
        checks++;
        if (!done8) begin
            errors++;
            $display("FAIL timeout8: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic wait_done4();
        int n = 0;
        while (!done4 && n < 30) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (!done4) begin
            errors++;
            $display("FAIL timeout4: got no done after %0d cycles expected done", n);
        end
    endtask

    task automatic op8(input exp8_t v, input bit timing);
        int n, nb;
        @(negedge clk);
        a8 = v.a;
        b8 = v.b;
        start8 = 1'b1;
        q8.push_back(v);
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n, nb);
        if (timing) begin
            check("latency8", n, 8);
            check("busy_cycles8", nb, 8);
        end
    endtask

    task automatic op4(input logic [3:0] ta, input logic [3:0] tb_v);
        exp4_t e;
        logic [4:0] r;
        r = {1'b0, ta} - {1'b0, tb_v};
        e.a = ta;
        e.b = tb_v;
        e.diff = r[3:0];
        e.bout = r[4];
        e.zero = (r[3:0] == 4'd0);
        @(negedge clk);
        a4 = ta;
        b4 = tb_v;
        start4 = 1'b1;
        q4.push_back(e);
        @(negedge clk);
        start4 = 1'b0;
        wait_done4();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n, nb, nd, t;
        int times[3];
        exp8_t e;

        vecs[0] = '{a: 8'd200, b: 8'd55,  diff: 8'd145, bout: 1'b0, zero: 1'b0};
        vecs[1] = '{a: 8'd3,   b: 8'd10,  diff: 8'hF9,  bout: 1'b1, zero: 1'b0};
        vecs[2] = '{a: 8'hA5,  b: 8'hA5,  diff: 8'h00,  bout: 1'b0, zero: 1'b1};
        vecs[3] = '{a: 8'd0,   b: 8'd1,   diff: 8'hFF,  bout: 1'b1, zero: 1'b0};
        vecs[4] = '{a: 8'd255, b: 8'd0,   diff: 8'd255, bout: 1'b0, zero: 1'b0};
        vecs[5] = '{a: 8'd0,   b: 8'd0,   diff: 8'd0,   bout: 1'b0, zero: 1'b1};
        vecs[6] = '{a: 8'd128, b: 8'd1,   diff: 8'd127, bout: 1'b0, zero: 1'b0};
        vecs[7] = '{a: 8'd1,   b: 8'd255, diff: 8'd2,   bout: 1'b1, zero: 1'b0};

        rst_n = 1'b0;
        start8 = 1'b0; abort8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; abort4 = 1'b0; a4 = '0; b4 = '0;
        repeat (3) @(negedge clk);
        check("reset_state8", {busy8, done8, diff8, bout8, zero8}, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
        check("reset_state4", {busy4, done4, diff4, bout4, zero4}, {1'b0, 1'b0, 4'h0, 1'b0, 1'b1});
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset8", {busy8, done8}, 2'b00);

        // Table-driven vectors; the first also checks latency and busy length.
        for (int i = 0; i < 8; i++) begin
            op8(vecs[i], i == 0);
        end

        // Start pulse and operand changes during RUN must not restart the operation.
        @(negedge clk);
        a8 = 8'd100; b8 = 8'd30; start8 = 1'b1;
        e = '{a: 8'd100, b: 8'd30, diff: 8'd70, bout: 1'b0, zero: 1'b0};
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        @(negedge clk);
        a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        wait_done8(n, nb);
        check("latency_ignore_start8", n, 6);

        // Start held high: one operation every WIDTH+2 cycles.
        @(negedge clk);
        a8 = 8'd1; b8 = 8'd1; start8 = 1'b1;
        e = '{a: 8'd1, b: 8'd1, diff: 8'd0, bout: 1'b0, zero: 1'b1};
        repeat (3) q8.push_back(e);
        t = 0;
        nd = 0;
        while (nd < 3 && t < 60) begin
            @(negedge clk);
            t++;
            if (done8) begin
                times[nd] = t;
                nd++;
            end
        end
        start8 = 1'b0;
        check("held_done_count", nd, 3);
        check("held_first_done", times[0], 9);
        check("held_period_1", times[1] - times[0], 10);
        check("held_period_2", times[2] - times[1], 10);

        // Abort in the 4th RUN cycle: busy drops, no done, results held.
        op8(vecs[0], 1'b0);
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check("abort_busy_drop", {busy8, done8}, 2'b00);
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) nd++;
        end
        check("abort_no_done", nd, 0);
        check("abort_keep_result", {diff8, bout8, zero8}, {8'd145, 1'b0, 1'b0});

        // Abort on the final RUN edge wins over completion.
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd4; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (7) @(negedge clk);
        abort8 = 1'b1;
        @(negedge clk);
        abort8 = 1'b0;
        check("abort_last_no_done", {busy8, done8}, 2'b00);
        check("abort_last_keep", {diff8, bout8, zero8}, {8'd145, 1'b0, 1'b0});

        // Abort together with start in IDLE: start wins.
        @(negedge clk);
        a8 = 8'd9; b8 = 8'd4; start8 = 1'b1; abort8 = 1'b1;
        e = '{a: 8'd9, b: 8'd4, diff: 8'd5, bout: 1'b0, zero: 1'b0};
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0; abort8 = 1'b0;
        check("start_wins_busy", busy8, 1'b1);
        wait_done8(n, nb);

        // Asynchronous reset in the 5th RUN cycle, off the clock edge.
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd20; start8 = 1'b1;
        e = '{a: 8'd50, b: 8'd20, diff: 8'd30, bout: 1'b0, zero: 1'b0};
        q8.push_back(e);
        @(negedge clk);
        start8 = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        q8.delete();
        #1;
        check("async_reset_outputs", {busy8, done8, diff8, bout8, zero8}, {1'b0, 1'b0, 8'h00, 1'b0, 1'b1});
        #3;
        rst_n = 1'b1;
        op8(e, 1'b1);

        // Exhaustive 4-bit sweep.
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                op4(4'(ia), 4'(ib));
            end
        end

        @(negedge clk);
        check("scoreboard8_empty", q8.size(), 0);
        check("scoreboard4_empty", q4.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
